// File: rtl/cassette_player.sv
// Cassette playback engine: streams a tape image from SDRAM and FSK-encodes it onto the
// CoCo cassette input, one square cycle per bit, LSB first, paced by rising edges of Q.
module cassette_player #(
    parameter int ADDR_W    = 25,
    parameter int GAP_TICKS = 445000,
    parameter int HALF_ONE  = 186,
    parameter int HALF_ZERO = 373,
    parameter int NAME_GAP  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Q,
    input  logic              motor,
    input  logic              rewind,
    input  logic [ADDR_W-1:0] tape_len,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_rd,
    input  logic              sdram_ack,
    input  logic [7:0]        sdram_data,
    output logic              data,
    output logic              eot,
    output logic [2:0]        status
);

    localparam int GAP_W    = $clog2(GAP_TICKS + 1);
    localparam int HALF_MAX = (HALF_ONE > HALF_ZERO) ? HALF_ONE : HALF_ZERO;
    localparam int HALF_W   = $clog2(HALF_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GAP   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_ADV   = 3'd4;
    localparam logic [2:0] S_END   = 3'd5;

    logic [2:0]        state;
    logic              q_d;
    logic              tick;
    logic [2:0]        rw_s;
    logic              rw_edge;
    logic              rew_pend;
    logic              motor_d;
    logic              drop_pend;
    logic              stale;
    logic [GAP_W-1:0]  gap_cnt;
    logic [HALF_W-1:0] half_cnt;
    logic [HALF_W-1:0] half_cur;
    logic [HALF_W-1:0] half_nxt;
    logic [2:0]        bit_idx;
    logic              phase_lo;
    logic              armed;
    logic              data_q;
    logic [7:0]        byte_q;
    logic [23:0]       seq;
    logic [23:0]       nseq;
    logic              name;
    logic              eof;
    logic [ADDR_W-1:0] naddr;

    assign tick     = Q & ~q_d;
    assign rw_edge  = rw_s[1] & ~rw_s[2];
    assign nseq     = {seq[15:0], byte_q};
    assign naddr    = sdram_addr + ADDR_W'(1);
    assign half_cur = byte_q[bit_idx] ? HALF_W'(HALF_ONE - 1) : HALF_W'(HALF_ZERO - 1);
    assign half_nxt = byte_q[bit_idx + 3'd1] ? HALF_W'(HALF_ONE - 1) : HALF_W'(HALF_ZERO - 1);
    assign data     = data_q & motor & ~drop_pend;
    assign eot      = (state == S_END);
    assign status   = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            q_d        <= 1'b0;
            rw_s       <= '0;
            rew_pend   <= 1'b0;
            motor_d    <= 1'b0;
            drop_pend  <= 1'b0;
            stale      <= 1'b0;
            gap_cnt    <= '0;
            half_cnt   <= '0;
            bit_idx    <= '0;
            phase_lo   <= 1'b0;
            armed      <= 1'b0;
            data_q     <= 1'b0;
            byte_q     <= '0;
            seq        <= '0;
            name       <= 1'b0;
            eof        <= 1'b0;
            sdram_addr <= '0;
            sdram_rd   <= 1'b0;
        end else begin
            q_d     <= Q;
            motor_d <= motor;
            rw_s    <= {rw_s[1:0], rewind};

            // An ack for a request abandoned by motor-off/rewind is swallowed here;
            // if FETCH was re-entered meanwhile the request line simply stays up.
            if (sdram_ack && sdram_rd) begin
                if (stale) begin
                    stale    <= 1'b0;
                    sdram_rd <= (state == S_FETCH);
                end else begin
                    sdram_rd <= 1'b0;
                    if (state == S_FETCH) begin
                        byte_q   <= sdram_data;
                        state    <= S_SEND;
                        bit_idx  <= '0;
                        phase_lo <= 1'b0;
                        armed    <= 1'b0;
                        half_cnt <= '0;
                    end
                end
            end

            if (tick) begin
                if (rew_pend || drop_pend) begin
                    state     <= S_IDLE;
                    data_q    <= 1'b0;
                    rew_pend  <= 1'b0;
                    drop_pend <= 1'b0;
                    if (sdram_rd) begin
                        stale <= ~sdram_ack;
                        if (sdram_ack) sdram_rd <= 1'b0;
                    end
                    if (rew_pend) begin
                        sdram_addr <= '0;
                        seq        <= '0;
                        name       <= 1'b0;
                        eof        <= 1'b0;
                    end
                end else begin
                    case (state)
                        S_IDLE: if (motor) begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_W'(GAP_TICKS);
                        end
                        S_GAP: begin
                            if (gap_cnt <= GAP_W'(1)) begin
                                if (sdram_addr < tape_len) begin
                                    state    <= S_FETCH;
                                    sdram_rd <= 1'b1;
                                end else begin
                                    state <= S_END;
                                end
                            end else begin
                                gap_cnt <= gap_cnt - 1'b1;
                            end
                        end
                        S_SEND: begin
                            if (!armed) begin
                                armed    <= 1'b1;
                                data_q   <= 1'b1;
                                half_cnt <= half_cur;
                            end else if (half_cnt != '0) begin
                                half_cnt <= half_cnt - 1'b1;
                            end else if (!phase_lo) begin
                                phase_lo <= 1'b1;
                                data_q   <= 1'b0;
                                half_cnt <= half_cur;
                            end else if (bit_idx == 3'd7) begin
                                state <= S_ADV;
                            end else begin
                                bit_idx  <= bit_idx + 3'd1;
                                phase_lo <= 1'b0;
                                data_q   <= 1'b1;
                                half_cnt <= half_nxt;
                            end
                        end
                        S_ADV: begin
                            seq        <= nseq;
                            sdram_addr <= naddr;
                            if (nseq == 24'h553C00) name <= 1'b1;
                            if (nseq == 24'h553CFF) eof <= 1'b1;
                            if (nseq == 24'h00FF55 && eof) begin
                                state <= S_END;
                            end else if (nseq == 24'h555555 && name && NAME_GAP != 0) begin
                                // step back so the three leader bytes are replayed after the gap
                                name       <= 1'b0;
                                sdram_addr <= naddr - ADDR_W'(3);
                                seq        <= '0;
                                state      <= S_GAP;
                                gap_cnt    <= GAP_W'(GAP_TICKS);
                            end else if (naddr == tape_len) begin
                                state <= S_END;
                            end else begin
                                state    <= S_FETCH;
                                sdram_rd <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            if (rw_edge) rew_pend <= 1'b1;
            if (motor_d && !motor && state != S_END) drop_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cassette_player.sv
// Bench for cassette_player: expected per-tick (data, status, address) stream built from
// the byte image and the FSK rules, compared on every Q tick, plus literal spot checks.
`timescale 1ns/1ps
module tb_cassette_player;

    localparam int AW = 8;
    localparam int G  = 6;
    localparam int H1 = 2;
    localparam int H0 = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          Q = 1'b0;
    logic          motor;
    logic          rewind;
    logic [AW-1:0] tape_len;
    logic [AW-1:0] sdram_addr;
    logic          sdram_rd;
    logic          sdram_ack = 1'b0;
    logic [7:0]    sdram_data = 8'h00;
    logic          data;
    logic          eot;
    logic [2:0]    status;

    typedef struct packed {
        logic          d;
        logic [2:0]    s;
        logic [AW-1:0] a;
    } item_t;

    item_t         exp_q[$];
    item_t         cur;
    logic [7:0]    mem [0:31];
    logic [AW-1:0] req_log[$];
    int unsigned   ack_delay = 1;
    int unsigned   wait_cnt = 0;
    int            npass = 0;
    int            ntot = 0;
    int            tick_n = 0;
    logic          q_last = 1'b0;
    logic          is_t;
    logic [1:0]    qdiv = 2'd0;

    cassette_player #(
        .ADDR_W(AW), .GAP_TICKS(G), .HALF_ONE(H1), .HALF_ZERO(H0), .NAME_GAP(1)
    ) dut (
        .clk(clk), .reset(reset), .Q(Q), .motor(motor), .rewind(rewind),
        .tape_len(tape_len), .sdram_addr(sdram_addr), .sdram_rd(sdram_rd),
        .sdram_ack(sdram_ack), .sdram_data(sdram_data), .data(data), .eot(eot),
        .status(status)
    );

    always #5 clk = ~clk;

    // Q divider (one tick every 4 clks) and SDRAM responder with a programmable ack delay
    always @(negedge clk) begin
        qdiv = qdiv + 2'd1;
        Q = qdiv[1];
        if (sdram_ack) begin
            sdram_ack = 1'b0;
        end else if (sdram_rd) begin
            if (wait_cnt >= ack_delay) begin
                sdram_data = mem[sdram_addr[4:0]];
                sdram_ack  = 1'b1;
                req_log.push_back(sdram_addr);
                wait_cnt   = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        ntot++;
        if (act === ex) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    endtask

    always @(posedge clk) begin
        is_t = Q && !q_last;
        q_last = Q;
        if (is_t) begin
            tick_n++;
            if (exp_q.size() > 0) begin
                #1;
                cur = exp_q.pop_front();
                chk("tick_data", data, cur.d);
                chk("tick_status", status, cur.s);
                chk("tick_addr", sdram_addr, cur.a);
                chk("tick_eot", eot, cur.s == 3'd5);
            end
        end
    end

    task automatic push(input logic d, input logic [2:0] s, input logic [AW-1:0] a);
        item_t it;
        it.d = d; it.s = s; it.a = a;
        exp_q.push_back(it);
    endtask

    task automatic push_gap(input logic [AW-1:0] a);
        for (int i = 0; i < G; i++) push(1'b0, 3'd1, a);
    endtask

    // FSK waveform: per bit, LSB first, HALF ticks high then HALF ticks low
    task automatic push_wave(input logic [7:0] b, input logic [AW-1:0] a, input int n);
        int k = 0;
        for (int i = 0; i < 8; i++) begin
            int h = b[i] ? H1 : H0;
            for (int j = 0; j < 2 * h; j++) begin
                if (k < n) push(j < h, 3'd3, a);
                k++;
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic [AW-1:0] a);
        push(1'b0, 3'd2, a);
        push_wave(b, a, 1000);
        push(1'b0, 3'd4, a);
    endtask

    task automatic push_bytes(input int first, input int last);
        for (int a = first; a <= last; a++) push_byte(mem[a], AW'(a));
    endtask

    task automatic load(input logic [71:0] img, input int n);
        for (int i = 0; i < n; i++) mem[i] = img[8 * (n - 1 - i) +: 8];
        tape_len = AW'(n);
    endtask

    task automatic wait_tick();
        int n0 = tick_n;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tick_n != n0) return;
        end
        chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) return;
        end
        chk("drain_timeout", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic start_motor();
        wait_tick();
        motor = 1'b1;
    endtask

    task automatic do_rewind();
        motor = 1'b0;
        wait_tick();
        rewind = 1'b1;
        repeat (2) @(negedge clk);
        rewind = 1'b0;
        repeat (3) wait_tick();
        chk("rew_addr", sdram_addr, 32'd0);
        chk("rew_eot", eot, 32'd0);
        chk("rew_status", status, 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int hits;
        bit ok;
        reset = 1'b1; motor = 1'b0; rewind = 1'b0; tape_len = '0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_addr", sdram_addr, 32'd0);
        chk("rst_rd", sdram_rd, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_eot", eot, 32'd0);
        chk("rst_status", status, 32'd0);
        reset = 1'b0;

        // pin the model: 0x55 = 4*(2+2)+4*(3+3)+2, 0xFF = 8*(2+2)+2
        n0 = exp_q.size(); push_byte(8'h55, '0);
        chk("model_len_55", exp_q.size() - n0, 32'd42);
        exp_q.delete();
        n0 = exp_q.size(); push_byte(8'hFF, '0);
        chk("model_len_FF", exp_q.size() - n0, 32'd34);
        exp_q.delete();

        // 1: 55 3C 00 then end at tape_len
        load(72'h55_3C00, 3);
        start_motor();
        push_gap(8'd0); push_bytes(0, 2); push(1'b0, 3'd5, 8'd3);
        drain();
        chk("t1_eot", eot, 32'd1);
        chk("t1_addr", sdram_addr, 32'd3);
        do_rewind();

        // 2: filename block followed by leader -> step back 3, gap, replay
        load(72'h55_3C00_AA55_5555_11, 8);
        start_motor();
        push_gap(8'd0); push_bytes(0, 6);
        push_gap(8'd4); push_bytes(4, 7); push(1'b0, 3'd5, 8'd8);
        drain();
        chk("t2_addr", sdram_addr, 32'd8);
        do_rewind();

        // 3: EOF block terminates before the trailing 0xAA is requested
        load(72'h55_3CFF_00FF_55AA, 7);
        req_log.delete();
        start_motor();
        push_gap(8'd0); push_bytes(0, 5); push(1'b0, 3'd5, 8'd6);
        drain();
        repeat (3) wait_tick();
        hits = 0;
        foreach (req_log[i]) if (req_log[i] == 8'd6) hits++;
        chk("t3_aa_requests", hits, 32'd0);
        chk("t3_rd_idle", sdram_rd, 32'd0);
        chk("t3_status", status, 32'd5);
        do_rewind();

        // 4: tape_len=4
        load(72'h0102_0304, 4);
        start_motor();
        push_gap(8'd0); push_bytes(0, 3); push(1'b0, 3'd5, 8'd4);
        drain();
        chk("t4_addr", sdram_addr, 32'd4);
        chk("t4_eot", eot, 32'd1);
        do_rewind();

        // 5: motor drops during the first high half of byte 7
        load(72'h11_1213_1415_1617_5A21, 9);
        start_motor();
        push_gap(8'd0); push_bytes(0, 6); push(1'b0, 3'd2, 8'd7); push_wave(8'h5A, 8'd7, 2);
        drain();
        motor = 1'b0;
        #1;
        chk("t5_data_forced", data, 32'd0);
        push(1'b0, 3'd0, 8'd7);
        drain();
        chk("t5_addr_kept", sdram_addr, 32'd7);
        start_motor();
        push_gap(8'd7); push_bytes(7, 8); push(1'b0, 3'd5, 8'd9);
        drain();
        do_rewind();

        // tape_len=0 ends right after the first gap
        tape_len = '0;
        start_motor();
        push_gap(8'd0); push(1'b0, 3'd5, 8'd0);
        drain();
        do_rewind();

        // 6: ack delayed 50 clks; rd must stay high and nothing advances until the ack
        load(72'h33, 1);
        ack_delay = 50;
        start_motor();
        push_gap(8'd0); push(1'b0, 3'd2, 8'd0);
        drain();
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (sdram_ack) begin
                ok = 1'b1;
                break;
            end
            chk("t6_rd_held", sdram_rd, 32'd1);
            chk("t6_in_fetch", status, 32'd2);
            chk("t6_data_low", data, 32'd0);
        end
        if (!ok) chk("t6_ack_seen", 32'd0, 32'd1);
        push_wave(8'h33, 8'd0, 1000); push(1'b0, 3'd4, 8'd0); push(1'b0, 3'd5, 8'd1);
        drain();
        chk("t6_eot", eot, 32'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
